// File: rtl/mii_pkg.sv
// Shared encodings for the UART-to-MII return path: receiver/transmitter state
// enums and the fixed MII preamble/SFD constants.
package mii_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_PREAMBLE,
      TX_SFD,
      TX_DATA,
      TX_IPG
   } tx_state_t;

   localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
   localparam logic [3:0] SFD_NIBBLE      = 4'hD;
   localparam int         PREAMBLE_LEN    = 15;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit start validation, LSB-first
// deserializer; a byte whose stop bit is not 1 is discarded.
//
// state    | meaning
// RX_IDLE  | waiting for a high-to-low edge on the synced line
// RX_START | half a bit time, then re-check that the start bit is still low
// RX_DATA  | sample 8 data bits at bit centres, LSB first
// RX_STOP  | sample stop bit; pulse rx_dv only if it reads 1
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_serial,
   output logic       rx_sync,
   output logic       rx_dv,
   output logic [7:0] rx_byte
);
   import mii_pkg::*;

   localparam int CW = $clog2(CLKS_PER_BIT);

   rx_state_t     state, state_nxt;
   logic          sync_a, rx_prev;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          cnt_tc;

   assign cnt_tc = (cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a  <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync_a  <= rx_serial;
         rx_sync <= sync_a;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= RX_IDLE;
      else          state <= state_nxt;
   end

   // Start is edge-triggered so a framing error with the line still low
   // cannot be mistaken for a fresh start bit.
   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE:  if (!rx_sync && rx_prev) state_nxt = RX_START;
         RX_START: if (cnt_tc) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (cnt_tc && bit_idx == 3'd7) state_nxt = RX_STOP;
         RX_STOP:  if (cnt_tc) state_nxt = RX_IDLE;
         default:  state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            RX_IDLE: begin
               cnt     <= CW'(CLKS_PER_BIT / 2 - 1);
               bit_idx <= '0;
            end
            RX_START: cnt <= cnt_tc ? CW'(CLKS_PER_BIT - 1) : cnt - CW'(1);
            RX_DATA: begin
               if (cnt_tc) begin
                  cnt     <= CW'(CLKS_PER_BIT - 1);
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RX_STOP: if (!cnt_tc) cnt <= cnt - CW'(1);
            default: cnt <= '0;
         endcase
      end
   end

   always_comb begin
      rx_dv   = (state == RX_STOP) && cnt_tc && rx_sync;
      rx_byte = shreg;
   end

endmodule

// File: rtl/serial2mii.sv
// UART-to-MII return path: buffers UART bytes, closes a frame on line idle
// time and transmits it as preamble + SFD + payload + IPG on a self-generated MII clock.
//
// state       | meaning
// TX_IDLE     | tx_en low; leave on the first nibble strobe while busy
// TX_PREAMBLE | 15 nibbles of 0x5
// TX_SFD      | one nibble 0xD; first payload byte is popped here
// TX_DATA     | low nibble then high nibble per byte, back to back
// TX_IPG      | IPG_NIBBLES nibbles of forced idle, then release busy
module serial2mii #(
   parameter int CLKS_PER_BIT = 868,
   parameter int MII_DIV      = 2,
   parameter int IDLE_BITS    = 20,
   parameter int FIFO_DEPTH   = 128,
   parameter int IPG_NIBBLES  = 24
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_rx_serial,
   output logic       mii_tx_clk,
   output logic       mii_tx_en,
   output logic [3:0] mii_txd,
   output logic       busy,
   output logic       overflow
);
   import mii_pkg::*;

   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CNTW     = AW + 1;
   localparam int IDLE_LIM = IDLE_BITS * CLKS_PER_BIT;
   localparam int TW       = $clog2(IDLE_LIM + 1);
   localparam int DW       = (2 * MII_DIV > 1) ? $clog2(2 * MII_DIV) : 1;
   localparam int NMAX     = (IPG_NIBBLES > PREAMBLE_LEN) ? IPG_NIBBLES : PREAMBLE_LEN;
   localparam int NW       = $clog2(NMAX + 1);

   logic            rx_sync, rx_dv;
   logic [7:0]      rx_byte;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] occ, pend_cnt, frame_len, bytes_left;
   logic            full, wr_en, rd_en;

   logic [TW-1:0]   idle_timer;
   logic            idle_sat, commit;

   logic [DW-1:0]   div, div_nxt;
   logic            strobe;

   tx_state_t       state, state_nxt;
   logic [NW-1:0]   nib_cnt;
   logic            nib_tc, hi, last_byte;
   logic [7:0]      cur_byte;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_serial (uart_rx_serial),
      .rx_sync   (rx_sync),
      .rx_dv     (rx_dv),
      .rx_byte   (rx_byte)
   );

   // A byte arriving at full is still accepted when a pop happens that cycle.
   assign full  = (occ == CNTW'(FIFO_DEPTH));
   assign wr_en = rx_dv && (!full || rd_en);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= rx_byte;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   occ <= occ + CNTW'(1);
            2'b01:   occ <= occ - CNTW'(1);
            default: occ <= occ;
         endcase
         if (rx_dv && !wr_en) overflow <= 1'b1;
      end
   end

   assign idle_sat = (idle_timer == TW'(IDLE_LIM));
   assign commit   = idle_sat && (pend_cnt != '0) && (state == TX_IDLE) && !busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_timer <= '0;
         pend_cnt   <= '0;
      end else begin
         if (rx_dv || !rx_sync) idle_timer <= '0;
         else if (!idle_sat)    idle_timer <= idle_timer + TW'(1);
         if (commit) pend_cnt <= CNTW'(wr_en);
         else        pend_cnt <= pend_cnt + CNTW'(wr_en);
      end
   end

   // The cycle the divider wraps to 0 is the falling edge of mii_tx_clk.
   assign strobe  = (div == DW'(2 * MII_DIV - 1));
   assign div_nxt = strobe ? '0 : div + DW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div        <= '0;
         mii_tx_clk <= 1'b0;
      end else begin
         div        <= div_nxt;
         mii_tx_clk <= (div_nxt >= DW'(MII_DIV));
      end
   end

   assign nib_tc    = (nib_cnt == '0);
   assign last_byte = (bytes_left == CNTW'(1));
   assign rd_en     = strobe && ((state == TX_SFD) || (state == TX_DATA && hi && !last_byte));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= TX_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (strobe) begin
         case (state)
            TX_IDLE:     if (busy) state_nxt = TX_PREAMBLE;
            TX_PREAMBLE: if (nib_tc) state_nxt = TX_SFD;
            TX_SFD:      state_nxt = TX_DATA;
            TX_DATA:     if (hi && last_byte) state_nxt = TX_IPG;
            TX_IPG:      if (nib_tc) state_nxt = TX_IDLE;
            default:     state_nxt = TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nib_cnt    <= '0;
         hi         <= 1'b0;
         bytes_left <= '0;
         frame_len  <= '0;
         cur_byte   <= '0;
         busy       <= 1'b0;
      end else begin
         if (commit) begin
            busy      <= 1'b1;
            frame_len <= pend_cnt;
         end
         if (strobe) begin
            case (state)
               TX_IDLE:     nib_cnt <= NW'(PREAMBLE_LEN - 1);
               TX_PREAMBLE: nib_cnt <= nib_cnt - NW'(1);
               TX_SFD: begin
                  bytes_left <= frame_len;
                  hi         <= 1'b0;
                  cur_byte   <= mem[rd_ptr];
               end
               TX_DATA: begin
                  if (!hi) begin
                     hi <= 1'b1;
                  end else begin
                     hi         <= 1'b0;
                     bytes_left <= bytes_left - CNTW'(1);
                     if (last_byte) nib_cnt  <= NW'(IPG_NIBBLES - 1);
                     else           cur_byte <= mem[rd_ptr];
                  end
               end
               TX_IPG: begin
                  if (nib_tc) busy <= 1'b0;
                  else        nib_cnt <= nib_cnt - NW'(1);
               end
               default: nib_cnt <= '0;
            endcase
         end
      end
   end

   always_comb begin
      mii_tx_en = 1'b0;
      mii_txd   = 4'h0;
      case (state)
         TX_PREAMBLE: begin
            mii_tx_en = 1'b1;
            mii_txd   = PREAMBLE_NIBBLE;
         end
         TX_SFD: begin
            mii_tx_en = 1'b1;
            mii_txd   = SFD_NIBBLE;
         end
         TX_DATA: begin
            mii_tx_en = 1'b1;
            mii_txd   = hi ? cur_byte[7:4] : cur_byte[3:0];
         end
         default: begin
            mii_tx_en = 1'b0;
            mii_txd   = 4'h0;
         end
      endcase
   end

endmodule

// File: tb/tb_serial2mii.sv
// Scoreboard bench for serial2mii: UART stimulus pushes expected frames, a
// monitor reassembles MII frames at mii_tx_clk rising edges and compares.
module tb_serial2mii;
   localparam int CPB        = 8;
   localparam int MII_DIV    = 2;
   localparam int IDLE_BITS  = 20;
   localparam int FIFO_DEPTH = 128;
   localparam int IPG        = 24;
   localparam int PRE        = 15;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic       mii_tx_clk, mii_tx_en, busy, overflow;
   logic [3:0] mii_txd;

   serial2mii #(
      .CLKS_PER_BIT (CPB),
      .MII_DIV      (MII_DIV),
      .IDLE_BITS    (IDLE_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .IPG_NIBBLES  (IPG)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .uart_rx_serial (rx),
      .mii_tx_clk     (mii_tx_clk),
      .mii_tx_en      (mii_tx_en),
      .mii_txd        (mii_txd),
      .busy           (busy),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   logic [7:0] exp_bytes[$];
   int         exp_len[$];

   function automatic void check(string name, bit ok, longint act, longint req);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t", name, act, act, req, req, $time);
   endfunction

   // ---------------- monitor ----------------
   logic [3:0] nibs[$];
   bit   prev_tx_clk = 0, prev_en = 0, prev_busy = 0, prev_rst = 0;
   logic [3:0] prev_txd = 0;
   bit   in_frame = 0, have_prev = 0, ipg_armed = 0, have_rise = 0;
   int   gap_cnt = 0, ipg_cnt = 0, cyc_since_rise = 0;
   int   period_err = 0, period_n = 0, edge_err = 0;

   function automatic void check_frame();
      int n, pre5, len;
      logic [7:0] got, want;
      n = nibs.size();
      pre5 = 0;
      while (pre5 < n && nibs[pre5] == 4'h5) pre5++;
      check("preamble_len", pre5 == PRE, pre5, PRE);
      check("sfd", n > PRE && nibs[PRE] == 4'hD, (n > PRE) ? nibs[PRE] : 0, 4'hD);
      if (exp_len.size() == 0) begin
         check("frame_expected", 1'b0, 1, 0);
         return;
      end
      len = exp_len.pop_front();
      check("frame_len", (n - PRE - 1) == 2 * len, (n - PRE - 1) / 2, len);
      for (int i = 0; i < len; i++) begin
         got  = (PRE + 2 + 2 * i < n) ? {nibs[PRE + 2 + 2 * i], nibs[PRE + 1 + 2 * i]} : 8'h00;
         want = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'h00;
         check("payload_byte", got == want, got, want);
      end
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         nibs.delete();
         in_frame  = 0;
         have_prev = 0;
         ipg_armed = 0;
         have_rise = 0;
         prev_rst  = 0;
      end else begin
         if (prev_rst && ({mii_tx_en, mii_txd} != {prev_en, prev_txd}) && !(prev_tx_clk && !mii_tx_clk))
            edge_err++;
         cyc_since_rise++;
         if (!prev_tx_clk && mii_tx_clk) begin
            if (have_rise) begin
               period_n++;
               if (cyc_since_rise != 2 * MII_DIV) period_err++;
            end
            have_rise      = 1;
            cyc_since_rise = 0;
            if (mii_tx_en) begin
               if (!in_frame) begin
                  if (have_prev) check("ipg_gap", gap_cnt >= IPG, gap_cnt, IPG);
                  in_frame = 1;
                  nibs.delete();
               end
               nibs.push_back(mii_txd);
            end else begin
               if (in_frame) begin
                  check_frame();
                  in_frame  = 0;
                  have_prev = 1;
                  gap_cnt   = 0;
                  ipg_cnt   = 0;
                  ipg_armed = 1;
               end
               gap_cnt++;
               if (ipg_armed && busy) ipg_cnt++;
            end
         end
         if (prev_busy && !busy && ipg_armed) begin
            check("busy_after_ipg", ipg_cnt == IPG, ipg_cnt, IPG);
            ipg_armed = 0;
         end
         prev_rst = 1;
      end
      prev_tx_clk = mii_tx_clk;
      prev_en     = mii_tx_en;
      prev_txd    = mii_txd;
      prev_busy   = busy;
   end

   // ---------------- stimulus ----------------
   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
   endtask

   task automatic send_expected(input logic [7:0] b);
      exp_bytes.push_back(b);
      send_byte(b, 1'b1);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((exp_len.size() != 0 || busy) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check(name, n < budget, n, budget);
      repeat (10) @(posedge clk);
   endtask

   task automatic wait_tx_en(input string name, input int budget);
      int n = 0;
      while (!mii_tx_en && n < budget) begin
         @(posedge clk);
         n++;
      end
      check(name, n < budget, n, budget);
   endtask

   initial begin
      repeat (5) @(posedge clk);
      #1;
      check("rst_tx_clk",   mii_tx_clk == 1'b0, mii_tx_clk, 0);
      check("rst_tx_en",    mii_tx_en == 1'b0,  mii_tx_en, 0);
      check("rst_txd",      mii_txd == 4'h0,    mii_txd, 0);
      check("rst_busy",     busy == 1'b0,       busy, 0);
      check("rst_overflow", overflow == 1'b0,   overflow, 0);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (20) @(posedge clk);

      // three bytes, then idle
      exp_len.push_back(3);
      send_expected(8'h01);
      send_expected(8'h02);
      send_expected(8'hA5);
      wait_done("t1_done", 3000);

      // bad stop bit between two good bytes
      exp_len.push_back(2);
      send_expected(8'h11);
      send_byte(8'h99, 1'b0);
      repeat (2 * CPB) @(posedge clk);
      send_expected(8'h22);
      wait_done("t2_done", 3000);
      check("no_overflow_yet", overflow == 1'b0, overflow, 0);

      // 130 back-to-back bytes: last two dropped
      exp_len.push_back(FIFO_DEPTH);
      for (int i = 0; i < 130; i++) begin
         if (i < FIFO_DEPTH) send_expected(8'(i + 1));
         else                send_byte(8'(i + 1), 1'b1);
      end
      @(posedge clk); #1;
      check("overflow_set", overflow == 1'b1, overflow, 1);
      wait_done("t3_done", 5000);

      // second burst arrives during the first frame's DATA phase
      exp_len.push_back(40);
      for (int i = 0; i < 40; i++) send_expected(8'(8'h40 + i));
      wait_tx_en("t4_tx_start", 1000);
      repeat (80) @(posedge clk);
      exp_len.push_back(3);
      send_expected(8'hC1);
      send_expected(8'hC2);
      send_expected(8'hC3);
      wait_done("t4_done", 4000);
      check("overflow_sticky", overflow == 1'b1, overflow, 1);

      // reset in the middle of DATA aborts the frame
      for (int i = 0; i < 8; i++) send_byte(8'(8'h70 + i), 1'b1);
      wait_tx_en("t5_tx_start", 1000);
      repeat (80) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("abort_tx_en", mii_tx_en == 1'b0, mii_tx_en, 0);
      check("abort_txd",   mii_txd == 4'h0,   mii_txd, 0);
      check("abort_busy",  busy == 1'b0,      busy, 0);
      check("abort_overflow_clr", overflow == 1'b0, overflow, 0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (20) @(posedge clk);
      exp_len.push_back(1);
      send_expected(8'h3C);
      wait_done("t5_done", 3000);

      check("tx_clk_period", period_err == 0 && period_n > 0, period_err, 0);
      check("txd_on_falling_edge", edge_err == 0, edge_err, 0);
      check("scoreboard_empty", exp_bytes.size() == 0, exp_bytes.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
